encrypt: RTL and testbench

ENCRYPT -- requirements
Module: encrypt

---
 rtl/encrypt_pkg.sv | 29 ++
 rtl/encrypt_if.sv | 24 ++
 rtl/encrypt_s_mem.sv | 21 ++
 rtl/encrypt.sv | 209 ++++++++++++++++++++
 tb/tb_encrypt.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/encrypt_pkg.sv
// Shared constants and types for the ARC4 encrypt/crack blocks.
package encrypt_pkg;

  // Printable ASCII window used to judge plaintext readability.
  localparam logic [7:0] PrintLo = 8'h20;
  localparam logic [7:0] PrintHi = 8'h7E;

  typedef enum logic [3:0] {
    StIdle,
    StInit,
    StKsaRdI,
    StKsaRdJ,
    StKsaWrI,
    StKsaWrJ,
    StWriteLen,
    StPrgaRdI,
    StPrgaRdJ,
    StPrgaWrI,
    StPrgaWrJ,
    StPrgaRdPad,
    StPrgaWrCt,
    StDone
  } state_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PrintLo) && (b <= PrintHi);
  endfunction

endpackage

// File: rtl/encrypt_if.sv
// Handshake plus plaintext/ciphertext memory bus for the encrypt block.
interface encrypt_if;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_rddata;
  logic [7:0]  ct_addr;
  logic [7:0]  ct_wrdata;
  logic        ct_wren;
  logic        pt_ok;

  // Requester side: starts runs and owns the external memories.
  modport master (
    output en, key, pt_rddata,
    input  rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, pt_ok
  );

  // Encrypt side.
  modport slave (
    input  en, key, pt_rddata,
    output rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, pt_ok
  );
endinterface

// File: rtl/encrypt_s_mem.sv
// 256x8 single-port S-box RAM with registered (synchronous) read.
module encrypt_s_mem (
  input  logic       clk_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic       we_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [256];
  logic [7:0] rdata_q;

  // Write-enable store; read returns the pre-write contents of addr_i.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/encrypt.sv
// ARC4 encryptor: length-prefixed plaintext in, length-prefixed ciphertext out.
module encrypt
  import encrypt_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  encrypt_if.slave bus
);

  state_e      state_q, state_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [8:0]  k_q, k_d;
  logic [1:0]  km_q, km_d;
  logic [23:0] key_q, key_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  si_q, si_d;
  logic [7:0]  sj_q, sj_d;
  logic        pt_ok_q, pt_ok_d;

  logic [7:0]  s_addr, s_wdata, s_rdata;
  logic        s_we;
  logic [7:0]  pt_addr, ct_addr, ct_wrdata;
  logic        ct_wren, rdy;

  logic [7:0]  key_byte, ksa_j, prga_j, pad_addr, i_inc;

  encrypt_s_mem s_mem (
    .clk_i   (clk),
    .addr_i  (s_addr),
    .wdata_i (s_wdata),
    .we_i    (s_we),
    .rdata_o (s_rdata)
  );

  // Key byte for i mod 3, tracked by a wrapping 0..2 counter.
  always_comb begin
    case (km_q)
      2'd0:    key_byte = key_q[23:16];
      2'd1:    key_byte = key_q[15:8];
      default: key_byte = key_q[7:0];
    endcase
  end

  assign ksa_j    = j_q + s_rdata + key_byte;
  assign prga_j   = j_q + s_rdata;
  assign pad_addr = si_q + sj_q;
  assign i_inc    = i_q + 8'd1;

  // Next-state and output decode for the INIT/KSA/PRGA sequence.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    km_d      = km_q;
    key_d     = key_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    pt_ok_d   = pt_ok_q;
    s_addr    = i_q;
    s_wdata   = 8'h00;
    s_we      = 1'b0;
    pt_addr   = 8'h00;
    ct_addr   = 8'h00;
    ct_wrdata = 8'h00;
    ct_wren   = 1'b0;
    rdy       = 1'b0;

    case (state_q)
      StIdle: begin
        rdy = 1'b1;
        if (bus.en) begin
          key_d   = bus.key;
          i_d     = 8'h00;
          pt_ok_d = 1'b0;
          state_d = StInit;
        end
      end
      StInit: begin
        s_addr  = i_q;
        s_wdata = i_q;
        s_we    = 1'b1;
        i_d     = i_inc;
        if (i_q == 8'hFF) begin
          j_d     = 8'h00;
          km_d    = 2'd0;
          state_d = StKsaRdI;
        end
      end
      StKsaRdI: begin
        s_addr  = i_q;
        state_d = StKsaRdJ;
      end
      StKsaRdJ: begin
        si_d    = s_rdata;
        j_d     = ksa_j;
        s_addr  = ksa_j;
        state_d = StKsaWrI;
      end
      StKsaWrI: begin
        s_addr  = i_q;
        s_wdata = s_rdata;
        s_we    = 1'b1;
        state_d = StKsaWrJ;
      end
      StKsaWrJ: begin
        // When i == j this rewrites the original S[i], leaving S unchanged.
        s_addr  = j_q;
        s_wdata = si_q;
        s_we    = 1'b1;
        i_d     = i_inc;
        km_d    = (km_q == 2'd2) ? 2'd0 : km_q + 2'd1;
        state_d = (i_q == 8'hFF) ? StWriteLen : StKsaRdI;
      end
      StWriteLen: begin
        // pt_addr has sat at 0 throughout KSA, so pt_rddata holds the length.
        ct_addr   = 8'h00;
        ct_wrdata = bus.pt_rddata;
        ct_wren   = 1'b1;
        len_d     = bus.pt_rddata;
        pt_ok_d   = 1'b1;
        i_d       = 8'h00;
        j_d       = 8'h00;
        k_d       = 9'd1;
        state_d   = (bus.pt_rddata == 8'h00) ? StDone : StPrgaRdI;
      end
      StPrgaRdI: begin
        i_d     = i_inc;
        s_addr  = i_inc;
        state_d = StPrgaRdJ;
      end
      StPrgaRdJ: begin
        si_d    = s_rdata;
        j_d     = prga_j;
        s_addr  = prga_j;
        state_d = StPrgaWrI;
      end
      StPrgaWrI: begin
        sj_d    = s_rdata;
        s_addr  = i_q;
        s_wdata = s_rdata;
        s_we    = 1'b1;
        state_d = StPrgaWrJ;
      end
      StPrgaWrJ: begin
        s_addr  = j_q;
        s_wdata = si_q;
        s_we    = 1'b1;
        state_d = StPrgaRdPad;
      end
      StPrgaRdPad: begin
        s_addr  = pad_addr;
        pt_addr = k_q[7:0];
        state_d = StPrgaWrCt;
      end
      StPrgaWrCt: begin
        ct_addr   = k_q[7:0];
        ct_wrdata = bus.pt_rddata ^ s_rdata;
        ct_wren   = 1'b1;
        if (!is_printable(bus.pt_rddata)) pt_ok_d = 1'b0;
        k_d       = k_q + 9'd1;
        state_d   = (k_q == {1'b0, len_q}) ? StDone : StPrgaRdI;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      i_q     <= 8'h00;
      j_q     <= 8'h00;
      k_q     <= 9'd0;
      km_q    <= 2'd0;
      key_q   <= 24'h0;
      len_q   <= 8'h00;
      si_q    <= 8'h00;
      sj_q    <= 8'h00;
      pt_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      km_q    <= km_d;
      key_q   <= key_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      pt_ok_q <= pt_ok_d;
    end
  end

  assign bus.rdy       = rdy;
  assign bus.pt_addr   = pt_addr;
  assign bus.ct_addr   = ct_addr;
  assign bus.ct_wrdata = ct_wrdata;
  assign bus.ct_wren   = ct_wren;
  assign bus.pt_ok     = pt_ok_q;

endmodule

// File: tb/tb_encrypt.sv
// Directed bench for encrypt with behavioural pt/ct memories.
module tb_encrypt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  encrypt_if ifc ();

  encrypt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic       clr = 1'b0;
  int         ct_limit = 255;
  int         ct_writes = 0;
  int         ct_over = 0;
  int         pt_far = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  localparam logic [23:0] KeyStr = 24'h4B6579;

  // Synchronous pt read, ct capture, and write/read bookkeeping.
  always @(posedge clk) begin
    ifc.pt_rddata <= pt_mem[ifc.pt_addr];
    if (clr) begin
      for (int a = 0; a < 256; a++) ct_mem[a] <= 8'h5A;
      ct_writes <= 0;
      ct_over   <= 0;
      pt_far    <= 0;
    end else begin
      if (ifc.ct_wren) begin
        ct_mem[ifc.ct_addr] <= ifc.ct_wrdata;
        ct_writes <= ct_writes + 1;
        if (int'(ifc.ct_addr) > ct_limit) ct_over <= ct_over + 1;
      end
      if (!ifc.rdy && int'(ifc.pt_addr) > ct_limit) pt_far <= pt_far + 1;
    end
  end

  task automatic clear_ct(input int limit);
    ct_limit = limit;
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic load_plaintext();
    string s;
    s = "Plaintext";
    for (int a = 0; a < 256; a++) pt_mem[a] = 8'h00;
    pt_mem[0] = 8'd9;
    for (int a = 0; a < 9; a++) pt_mem[a + 1] = s[a];
  endtask

  // Start a run and wait for rdy; optionally hold en high mid-run.
  task automatic start_and_wait(input logic [23:0] k, input int hold_at, output int cycles);
    @(negedge clk);
    ifc.en  = 1'b1;
    ifc.key = k;
    @(negedge clk);
    ifc.en  = 1'b0;
    ifc.key = 24'h0;
    n_cmp++;
    if (ifc.rdy !== 1'b0) begin
      $display("FAIL handshake_rdy_drop: got %b want 0", ifc.rdy);
      n_err++;
    end
    cycles = 1;
    while (ifc.rdy !== 1'b1 && cycles < 4000) begin
      if (hold_at > 0 && cycles >= hold_at && cycles < hold_at + 200) begin
        ifc.en  = 1'b1;
        ifc.key = 24'hFFFFFF;
      end else begin
        ifc.en  = 1'b0;
        ifc.key = 24'h0;
      end
      @(negedge clk);
      cycles++;
    end
    ifc.en  = 1'b0;
    ifc.key = 24'h0;
    n_cmp++;
    if (ifc.rdy !== 1'b1) begin
      $display("FAIL run_timeout: rdy %b after %0d cycles want 1", ifc.rdy, cycles);
      n_err++;
    end
  endtask

  task automatic test_reset();
    ifc.en  = 1'b0;
    ifc.key = 24'h0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ifc.rdy !== 1'b1) begin
      $display("FAIL reset_rdy: got %b want 1", ifc.rdy); n_err++;
    end
    n_cmp++;
    if (ifc.ct_wren !== 1'b0) begin
      $display("FAIL reset_ct_wren: got %b want 0", ifc.ct_wren); n_err++;
    end
    n_cmp++;
    if (ifc.pt_ok !== 1'b0) begin
      $display("FAIL reset_pt_ok: got %b want 0", ifc.pt_ok); n_err++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plaintext();
    logic [7:0] exp [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF,
                             8'h0A, 8'hD3};
    int cyc;
    load_plaintext();
    clear_ct(9);
    start_and_wait(KeyStr, 0, cyc);
    for (int a = 0; a < 10; a++) begin
      n_cmp++;
      if (ct_mem[a] !== exp[a]) begin
        $display("FAIL plaintext_ct[%0d]: got %h want %h", a, ct_mem[a], exp[a]); n_err++;
      end
    end
    n_cmp++;
    if (ct_writes != 10 || ct_over != 0) begin
      $display("FAIL plaintext_writes: got %0d (%0d high) want 10 (0 high)", ct_writes, ct_over);
      n_err++;
    end
    n_cmp++;
    if (ifc.pt_ok !== 1'b1) begin
      $display("FAIL plaintext_pt_ok: got %b want 1", ifc.pt_ok); n_err++;
    end
    n_cmp++;
    if (cyc > 256 + 256 * 6 + 9 * 8 + 8) begin
      $display("FAIL plaintext_runtime: got %0d want <= %0d", cyc, 256 + 256 * 6 + 80); n_err++;
    end
  endtask

  task automatic test_len_zero();
    int cyc;
    for (int a = 0; a < 256; a++) pt_mem[a] = 8'h41;
    pt_mem[0] = 8'h00;
    clear_ct(0);
    start_and_wait(24'h000000, 0, cyc);
    n_cmp++;
    if (ct_writes != 1) begin
      $display("FAIL len0_writes: got %0d want 1", ct_writes); n_err++;
    end
    n_cmp++;
    if (ct_mem[0] !== 8'h00) begin
      $display("FAIL len0_ct0: got %h want 00", ct_mem[0]); n_err++;
    end
    n_cmp++;
    if (ifc.pt_ok !== 1'b1) begin
      $display("FAIL len0_pt_ok: got %b want 1", ifc.pt_ok); n_err++;
    end
    n_cmp++;
    if (pt_far != 0) begin
      $display("FAIL len0_pt_reads: got %0d reads above 0 want 0", pt_far); n_err++;
    end
    n_cmp++;
    if (cyc > 256 + 256 * 6 + 8) begin
      $display("FAIL len0_runtime: got %0d want <= %0d", cyc, 256 + 256 * 6 + 8); n_err++;
    end
  endtask

  task automatic test_len_max();
    logic [7:0] exp [5] = '{8'hFF, 8'hAA, 8'hDE, 8'h36, 8'hC0};
    int cyc;
    int bad;
    int first_bad;
    logic [7:0] want;
    for (int a = 1; a < 256; a++) pt_mem[a] = 8'h41;
    pt_mem[0] = 8'hFF;
    clear_ct(255);
    start_and_wait(KeyStr, 0, cyc);
    n_cmp++;
    if (ct_writes != 256) begin
      $display("FAIL len255_writes: got %0d want 256", ct_writes); n_err++;
    end
    for (int a = 0; a < 5; a++) begin
      n_cmp++;
      if (ct_mem[a] !== exp[a]) begin
        $display("FAIL len255_ct[%0d]: got %h want %h", a, ct_mem[a], exp[a]); n_err++;
      end
    end
    n_cmp++;
    if (ifc.pt_ok !== 1'b1) begin
      $display("FAIL len255_pt_ok: got %b want 1", ifc.pt_ok); n_err++;
    end
    n_cmp++;
    if (cyc > 256 + 256 * 6 + 255 * 8 + 8) begin
      $display("FAIL len255_runtime: got %0d want <= %0d", cyc, 256 + 256 * 6 + 2048); n_err++;
    end
    // Feed the ciphertext back in: same key must reproduce the plaintext.
    for (int a = 0; a < 256; a++) pt_mem[a] = ct_mem[a];
    clear_ct(255);
    start_and_wait(KeyStr, 0, cyc);
    bad = 0;
    first_bad = -1;
    for (int a = 0; a < 256; a++) begin
      want = (a == 0) ? 8'hFF : 8'h41;
      if (ct_mem[a] !== want) begin
        if (first_bad < 0) first_bad = a;
        bad++;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      $display("FAIL len255_redecrypt: %0d bad bytes, first at %0d got %h", bad, first_bad,
               ct_mem[(first_bad < 0) ? 0 : first_bad]);
      n_err++;
    end
  endtask

  task automatic test_en_ignored();
    logic [7:0] exp [4] = '{8'h03, 8'hAA, 8'h98, 8'h35};
    int cyc;
    for (int a = 0; a < 256; a++) pt_mem[a] = 8'h41;
    pt_mem[0] = 8'h03;
    pt_mem[1] = 8'h41;
    pt_mem[2] = 8'h07;
    pt_mem[3] = 8'h42;
    clear_ct(3);
    start_and_wait(KeyStr, 100, cyc);
    for (int a = 0; a < 4; a++) begin
      n_cmp++;
      if (ct_mem[a] !== exp[a]) begin
        $display("FAIL en_ignored_ct[%0d]: got %h want %h", a, ct_mem[a], exp[a]); n_err++;
      end
    end
    n_cmp++;
    if (ct_writes != 4 || ct_over != 0) begin
      $display("FAIL en_ignored_writes: got %0d (%0d high) want 4 (0 high)", ct_writes, ct_over);
      n_err++;
    end
    n_cmp++;
    if (ifc.pt_ok !== 1'b0) begin
      $display("FAIL en_ignored_pt_ok: got %b want 0", ifc.pt_ok); n_err++;
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    load_plaintext();
    clear_ct(9);
    @(negedge clk);
    ifc.en  = 1'b1;
    ifc.key = KeyStr;
    @(negedge clk);
    ifc.en  = 1'b0;
    ifc.key = 24'h0;
    waited = 0;
    while (ct_writes < 3 && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (ct_writes < 3) begin
      $display("FAIL reset_mid_reach_prga: got %0d writes want >= 3", ct_writes); n_err++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (ifc.rdy !== 1'b1) begin
      $display("FAIL reset_mid_rdy: got %b want 1", ifc.rdy); n_err++;
    end
    n_cmp++;
    if (ifc.ct_wren !== 1'b0) begin
      $display("FAIL reset_mid_ct_wren: got %b want 0", ifc.ct_wren); n_err++;
    end
    test_plaintext();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) pt_mem[a] = 8'h00;
    ifc.en  = 1'b0;
    ifc.key = 24'h0;
    test_reset();
    test_plaintext();
    test_len_zero();
    test_len_max();
    test_en_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
